// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write bundle for fifo_wr_arbiter: per-requester beat handshake
// plus the FIFO write port and arbiter status.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_cs;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          busy;
  logic [GW-1:0]                 grant_id;

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_cs, fifo_wr_en, fifo_data_in, busy, grant_id
  );

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_cs, fifo_wr_en, fifo_data_in, busy, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: grants one producer at a time for a burst
// (req_last or MAX_BURST beats) and steers its beats onto the FIFO write port.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]    r_state;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant_id;
  logic [7:0]    r_beat_cnt;

  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_next_ptr;
  logic          w_any_valid;
  logic          w_in_burst;
  logic          w_ready;
  logic          w_accept;
  logic          w_end;

  // First valid requester at or above ptr, wrapping at NUM_REQ (not 2**GW).
  function automatic logic [GW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [GW-1:0]      ptr);
    logic [GW-1:0] pick;
    logic          found;
    int unsigned   idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= 32'(NUM_REQ)) idx = idx - 32'(NUM_REQ);
      if (!found && valid[GW'(idx)]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_any_valid = |bus.req_valid;
  assign w_pick      = f_rr_pick(bus.req_valid, r_rr_ptr);
  assign w_in_burst  = (r_state == ST_BURST);
  assign w_ready     = w_in_burst && !bus.fifo_full;
  assign w_accept    = w_ready && bus.req_valid[r_grant_id];
  assign w_end       = w_accept &&
                       (bus.req_last[r_grant_id] || (r_beat_cnt == 8'(MAX_BURST - 1)));
  assign w_next_ptr  = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + GW'(1);

  always_comb begin
    bus.req_ready = '0;
    if (w_ready) bus.req_ready[r_grant_id] = 1'b1;
  end

  assign bus.fifo_wr_en   = w_accept;
  assign bus.fifo_wr_cs   = w_accept;
  // Data is forced to zero outside an accept so the write bus is quiet in IDLE/reset.
  assign bus.fifo_data_in = w_accept ? bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.busy         = w_in_burst;
  assign bus.grant_id     = r_grant_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_end) begin
              r_rr_ptr <= w_next_ptr;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
